// File: rtl/fifo_axil_arbiter_pkg.sv
// Shared types and constants for the simple_fifo AXI4-Lite arbiter.
//   state_t          : arbiter FSM states
//   RESP_*           : AXI response codes returned on rsp_resp
//   AXI_PROT_DEFAULT : fixed AxPROT value
//   AXI_STRB_ALL     : fixed WSTRB value (full 32-bit writes only)
//   idx_onehot()     : index to one-hot helper, up to 8 requesters
package fifo_axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_SLVERR      = 2'b10;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
    localparam logic [3:0] AXI_STRB_ALL     = 4'hF;

    function automatic logic [7:0] idx_onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/fifo_axil_arbiter_if.sv
// AXI4-Lite single-port bundle between the arbiter and simple_fifo S00_AXI.
//   master modport : arbiter side (drives AW/W/AR valids, addr, data, B/R readies)
//   slave modport  : register-interface side
interface fifo_axil_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/fifo_axil_arbiter_rr_pick.sv
// Round-robin picker, purely combinational.
//   req   : request vector
//   ptr   : index of the last granted requester; search starts at ptr+1 and wraps
//   grant : one-hot of the chosen requester (all zero when req is zero)
//   idx   : binary index of the chosen requester (0 when req is zero)
module fifo_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // i = NUM_REQ lands back on ptr itself, so it is checked last
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_axil_arbiter.sv
// Round-robin arbiter sharing the simple_fifo AXI4-Lite slave port between
// NUM_REQ local requesters; one single-beat transaction in flight at a time.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready : per-requester command handshake (ready is a one-hot pulse)
//   req_write/addr/wdata: per-requester command fields, packed
//   rsp_valid           : one-hot pulse to the requester that owned the transaction
//   rsp_rdata/rsp_resp  : read data (0 for writes) and AXI response code
//   busy                : high from accept through the response pulse
//   m_axi               : AXI4-Lite master port (fifo_axil_arbiter_if.master)
//   timeout_err         : sticky watchdog flag, only with FIFO_ARB_TIMEOUT_EN defined
//
// state  | meaning
// IDLE   | arbitrate; pulse req_ready and latch the winning command
// WR_REQ | AW and W presented, each dropped after its own handshake
// WR_RSP | bready high, waiting for B
// RD_REQ | AR presented until arready
// RD_RSP | rready high, waiting for R
// DONE   | rsp_valid pulse to the owner, back to IDLE
module fifo_axil_arbiter
    import fifo_axil_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          busy,
`ifdef FIFO_ARB_TIMEOUT_EN
    output logic                          timeout_err,
`endif
    fifo_axil_arbiter_if.master           m_axi
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("fifo_axil_arbiter: unsupported parameter set");
    end

    state_t                  state;
    state_t                  state_next;
    logic [IW-1:0]           ptr;
    logic [NUM_REQ-1:0]      pick_grant;
    logic [IW-1:0]           pick_idx;
    logic                    accept;
    logic                    timeout_hit;
    logic                    bready_c;
    logic                    rready_c;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    arvalid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]              rsp_resp_q;
    logic                    busy_q;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_write = req_write[i];
            end
        end
    end

    // Watchdog: down-counter reloaded on every state change, fires at zero
`ifdef FIFO_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_active;

    assign to_active   = (state == WR_REQ) || (state == WR_RSP) ||
                         (state == RD_REQ) || (state == RD_RSP);
    assign timeout_hit = to_active && (to_cnt == 16'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt <= 16'(TIMEOUT_CYCLES - 1);
        end else if (state_next != state || !to_active) begin
            to_cnt <= 16'(TIMEOUT_CYCLES - 1);
        end else begin
            to_cnt <= to_cnt - 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        bready_c   = 1'b0;
        rready_c   = 1'b0;
        rsp_valid  = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready  = pick_grant;
                    accept     = 1'b1;
                    state_next = sel_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // a channel whose valid has already dropped has completed
                if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
                    state_next = WR_RSP;
                end
            end
            WR_RSP: begin
                bready_c = !timeout_hit;
                if (m_axi.bvalid) begin
                    state_next = DONE;
                end
            end
            RD_REQ: begin
                if (m_axi.arready) begin
                    state_next = RD_RSP;
                end
            end
            RD_RSP: begin
                rready_c = !timeout_hit;
                if (m_axi.rvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp_valid  = NUM_REQ'(idx_onehot(3'(ptr)));
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (timeout_hit) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr         <= IW'(NUM_REQ - 1);
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            if (accept) begin
                ptr       <= pick_idx;
                busy_q    <= 1'b1;
                addr_q    <= sel_addr;
                wdata_q   <= sel_wdata;
                awvalid_q <= sel_write;
                wvalid_q  <= sel_write;
                arvalid_q <= !sel_write;
            end
            if (state == WR_REQ) begin
                if (awvalid_q && m_axi.awready) begin
                    awvalid_q <= 1'b0;
                end
                if (wvalid_q && m_axi.wready) begin
                    wvalid_q <= 1'b0;
                end
            end
            if (state == RD_REQ && arvalid_q && m_axi.arready) begin
                arvalid_q <= 1'b0;
            end
            if (bready_c && m_axi.bvalid) begin
                rsp_resp_q  <= m_axi.bresp;
                rsp_rdata_q <= '0;
            end
            if (rready_c && m_axi.rvalid) begin
                rsp_resp_q  <= m_axi.rresp;
                rsp_rdata_q <= m_axi.rdata;
            end
            if (state == DONE) begin
                busy_q <= 1'b0;
            end
            if (timeout_hit) begin
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rsp_resp_q  <= RESP_SLVERR;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = AXI_PROT_DEFAULT;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = AXI_STRB_ALL;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_c;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = AXI_PROT_DEFAULT;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_c;

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_axil_arbiter.sv
module tb_fifo_axil_arbiter;

    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic [1:0]       rsp_resp;
    logic             busy;
`ifdef FIFO_ARB_TIMEOUT_EN
    logic             timeout_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    fifo_axil_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

    fifo_axil_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .busy        (busy),
`ifdef FIFO_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .m_axi       (axil)
    );

    always #5 clock = ~clock;

    // Behavioural AXI4-Lite slave: 4-word memory, one-cycle B/R turnaround
    logic [31:0]   mem [4];
    logic          got_aw, got_w, r_pend, r_hold;
    logic [AW-1:0] aw_addr_l;
    logic [31:0]   w_data_l, r_word;
    logic          aw_hs, w_hs, ar_hs;
    int            b_count = 0;

    always @(posedge clock) begin
        aw_hs = axil.awvalid && axil.awready;
        w_hs  = axil.wvalid && axil.wready;
        ar_hs = axil.arvalid && axil.arready;
        if (reset) begin
            axil.bvalid <= 1'b0;
            axil.bresp  <= 2'b00;
            axil.rvalid <= 1'b0;
            axil.rresp  <= 2'b00;
            axil.rdata  <= '0;
            got_aw      <= 1'b0;
            got_w       <= 1'b0;
            r_pend      <= 1'b0;
        end else begin
            if (aw_hs) begin
                got_aw    <= 1'b1;
                aw_addr_l <= axil.awaddr;
            end
            if (w_hs) begin
                got_w    <= 1'b1;
                w_data_l <= axil.wdata;
            end
            if ((got_aw || aw_hs) && (got_w || w_hs) && !axil.bvalid) begin
                mem[aw_hs ? axil.awaddr[3:2] : aw_addr_l[3:2]] <= w_hs ? axil.wdata : w_data_l;
                axil.bvalid <= 1'b1;
                got_aw      <= 1'b0;
                got_w       <= 1'b0;
            end
            if (axil.bvalid && axil.bready) begin
                axil.bvalid <= 1'b0;
                b_count     <= b_count + 1;
            end
            if (ar_hs) begin
                r_word <= mem[axil.araddr[3:2]];
                r_pend <= 1'b1;
            end
            if ((ar_hs || r_pend) && !r_hold && !axil.rvalid) begin
                axil.rvalid <= 1'b1;
                axil.rdata  <= ar_hs ? mem[axil.araddr[3:2]] : r_word;
                r_pend      <= 1'b0;
            end
            if (axil.rvalid && axil.rready) begin
                axil.rvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        reset        = 1'b1;
        r_hold       = 1'b0;
        req_valid    = '0;
        req_write    = '0;
        req_addr     = '0;
        req_wdata    = '0;
        axil.awready = 1'b1;
        axil.wready  = 1'b1;
        axil.arready = 1'b1;
        repeat (3) step();
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_resp", rsp_resp, 0);
        check("rst_awvalid", axil.awvalid, 0);
        check("rst_wvalid", axil.wvalid, 0);
        check("rst_arvalid", axil.arvalid, 0);
        check("rst_bready", axil.bready, 0);
        check("rst_rready", axil.rready, 0);

        // single write: req1 writes A5A5_0001 to 0x0
        reset = 1'b0;
        req_valid = 4'b0010;
        req_write = 4'b0010;
        req_addr[4 +: 4]   = 4'h0;
        req_wdata[32 +: 32] = 32'hA5A5_0001;
        #1;
        check("wr_c0_ready", req_ready, 4'b0010);
        check("wr_c0_busy", busy, 0);
        step(); req_valid = '0; #1;
        check("wr_c1_awvalid", axil.awvalid, 1);
        check("wr_c1_wvalid", axil.wvalid, 1);
        check("wr_c1_awaddr", axil.awaddr, 4'h0);
        check("wr_c1_wdata", axil.wdata, 32'hA5A5_0001);
        check("wr_c1_wstrb", axil.wstrb, 4'hF);
        check("wr_c1_busy", busy, 1);
        check("wr_c1_ready", req_ready, 0);
        step(); #1;
        check("wr_c2_awvalid", axil.awvalid, 0);
        check("wr_c2_wvalid", axil.wvalid, 0);
        check("wr_c2_bready", axil.bready, 1);
        step(); #1;
        check("wr_c3_rsp_valid", rsp_valid, 4'b0010);
        check("wr_c3_resp", rsp_resp, 0);
        check("wr_c3_rdata", rsp_rdata, 0);
        check("wr_c3_busy", busy, 1);
        step(); #1;
        check("wr_c4_rsp_valid", rsp_valid, 0);
        check("wr_c4_busy", busy, 0);

        // readback: req2 reads 0x0
        req_valid = 4'b0100;
        req_write = 4'b0000;
        req_addr[8 +: 4] = 4'h0;
        #1;
        check("rd_c0_ready", req_ready, 4'b0100);
        step(); req_valid = '0; #1;
        check("rd_c1_arvalid", axil.arvalid, 1);
        check("rd_c1_araddr", axil.araddr, 4'h0);
        step(); #1;
        check("rd_c2_rready", axil.rready, 1);
        check("rd_c2_arvalid", axil.arvalid, 0);
        step(); #1;
        check("rd_c3_rsp_valid", rsp_valid, 4'b0100);
        check("rd_c3_rdata", rsp_rdata, 32'hA5A5_0001);
        check("rd_c3_resp", rsp_resp, 0);
        step(); #1;
        check("rd_c4_rsp_valid", rsp_valid, 0);

        // contention after reset: all four write their id to id*4
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'hF;
        req_write = 4'hF;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = AW'(i * 4);
            req_wdata[i*DW +: DW] = DW'(i);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_ready", req_ready, 64'(4'b0001 << (k % 4)));
            step(); #1;
            check("rr_awaddr", axil.awaddr, 64'((k % 4) * 4));
            check("rr_wdata", axil.wdata, 64'(k % 4));
            step();
            step(); #1;
            check("rr_rsp_valid", rsp_valid, 64'(4'b0001 << (k % 4)));
            if (k == 4) req_valid = '0;
            step();
        end

        // AW backpressure: W completes first, AW held three cycles
        axil.awready = 1'b0;
        req_valid = 4'b0010;
        req_write = 4'b0010;
        req_addr[4 +: 4]    = 4'h4;
        req_wdata[32 +: 32] = 32'hBEEF_0004;
        #1;
        check("bp_c0_ready", req_ready, 4'b0010);
        step(); req_valid = '0; #1;
        check("bp_c1_awvalid", axil.awvalid, 1);
        check("bp_c1_wvalid", axil.wvalid, 1);
        step(); #1;
        check("bp_c2_awvalid", axil.awvalid, 1);
        check("bp_c2_wvalid", axil.wvalid, 0);
        check("bp_c2_bready", axil.bready, 0);
        step(); #1;
        check("bp_c3_awvalid", axil.awvalid, 1);
        axil.awready = 1'b1;
        step(); #1;
        check("bp_c4_awvalid", axil.awvalid, 0);
        check("bp_c4_bready", axil.bready, 1);
        step(); #1;
        check("bp_c5_rsp_valid", rsp_valid, 4'b0010);
        step(); #1;
        check("bp_c6_rsp_valid", rsp_valid, 0);
        step(); #1;
        check("bp_c7_rsp_valid", rsp_valid, 0);
        check("bp_b_count", b_count, 7);

        // reset while waiting in RD_RSP
        r_hold = 1'b1;
        req_valid = 4'b0010;
        req_write = 4'b0000;
        req_addr[4 +: 4] = 4'hC;
        #1;
        check("rr_rst_c0_ready", req_ready, 4'b0010);
        step(); req_valid = '0; #1;
        check("rr_rst_c1_arvalid", axil.arvalid, 1);
        step(); #1;
        check("rr_rst_c2_rready", axil.rready, 1);
        step(); #1;
        check("rr_rst_c3_rready", axil.rready, 1);
        check("rr_rst_c3_rsp_valid", rsp_valid, 0);
        reset = 1'b1;
        step(); #1;
        check("rr_rst_arvalid", axil.arvalid, 0);
        check("rr_rst_rready", axil.rready, 0);
        check("rr_rst_awvalid", axil.awvalid, 0);
        check("rr_rst_bready", axil.bready, 0);
        check("rr_rst_rsp_valid", rsp_valid, 0);
        check("rr_rst_busy", busy, 0);
        reset  = 1'b0;
        r_hold = 1'b0;
        req_valid = 4'b0111;
        req_write = 4'b0000;
        req_addr[0 +: 4] = 4'h4;
        #1;
        check("post_rst_ready", req_ready, 4'b0001);
        step(); req_valid = '0; #1;
        check("post_rst_araddr", axil.araddr, 4'h4);
        step();
        step(); #1;
        check("post_rst_rsp_valid", rsp_valid, 4'b0001);
        check("post_rst_rdata", rsp_rdata, 32'hBEEF_0004);
        step();

`ifdef FIFO_ARB_TIMEOUT_EN
        // watchdog: arready stuck low for 16 cycles in RD_REQ
        axil.arready = 1'b0;
        req_valid = 4'b0100;
        req_write = 4'b0000;
        req_addr[8 +: 4] = 4'h8;
        #1;
        check("to_c0_ready", req_ready, 4'b0100);
        step(); req_valid = '0;
        repeat (15) step();
        #1;
        check("to_c16_arvalid", axil.arvalid, 1);
        check("to_c16_err", timeout_err, 0);
        step(); #1;
        check("to_c17_rsp_valid", rsp_valid, 4'b0100);
        check("to_c17_resp", rsp_resp, 2'b10);
        check("to_c17_rdata", rsp_rdata, 0);
        check("to_c17_arvalid", axil.arvalid, 0);
        check("to_c17_err", timeout_err, 1);
        axil.arready = 1'b1;
        step(); step(); #1;
        check("to_sticky_err", timeout_err, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
